key_conditioner: RTL and testbench



---
 rtl/key_cond_pkg.sv | 25 ++
 rtl/key_debounce_channel.sv | 123 ++++++++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // One counter covers every timing job, so it is sized by the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce/auto-repeat FSM and a shared saturating counter.
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  typedef logic [CW-1:0] cnt_t;

  // Debounce accepts on the edge where the count would reach the limit.
  localparam cnt_t DB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LIM  = cnt_t'(REPEAT_DELAY);
  localparam cnt_t RP_LIM  = cnt_t'(REPEAT_PERIOD);

  logic [1:0] sync_q;
  logic       s;
  key_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d, cnt_inc;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       rpt_q, rpt_d;

  assign s = ~sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
    cnt_d   = cnt_inc;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          rpt_d   = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q >= RD_LIM) begin
          state_d = REPEAT;
          cnt_d   = '0;
          rpt_d   = 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q >= RP_LIM) begin
          cnt_d = '0;
          rpt_d = 1'b1;
        end
      end
      DB_RELEASE: begin
        // A bounce back to pressed resumes repeating without restarting the count.
        if (s) begin
          state_d = REPEAT;
          cnt_d   = cnt_q;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign rpt_o   = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw active-low buttons into debounced level and pulse outputs.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                Reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] Level,
  output logic [NUM_KEYS-1:0] Press,
  output logic [NUM_KEYS-1:0] Release,
  output logic [NUM_KEYS-1:0] Repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk    (CLOCK_50),
      .rst_n  (Reset_n),
      .key_n  (KEY[i]),
      .level_o(Level[i]),
      .press_o(Press[i]),
      .rel_o  (Release[i]),
      .rpt_o  (Repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;

  logic       CLOCK_50 = 1'b0;
  logic       Reset_n;
  logic [2:0] KEY;
  logic [2:0] Level, Press, Release, Repeat;

  key_conditioner #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .Reset_n(Reset_n), .KEY(KEY),
    .Level(Level), .Press(Press), .Release(Release), .Repeat(Repeat)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // kind: 0 = Press, 1 = Repeat, 2 = Release
  typedef struct {int cyc; int kind; int ch;} ev_t;
  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic string kname(input int k);
    return (k == 0) ? "Press" : (k == 1) ? "Repeat" : "Release";
  endfunction

  task automatic push(input int at, input int kind, input int ch);
    ev_t e;
    e.cyc = at; e.kind = kind; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic push_press(input int at, input int ch);
    push(at, 0, ch);
    push(at, 1, ch);
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic step(input int k);
    at_edge(cyc + k);
  endtask

  // Monitor: every pulse must match a queued expectation; stale entries are misses.
  always @(negedge CLOCK_50) begin
    logic [2:0] v [3];
    int idx;
    v[0] = Press; v[1] = Repeat; v[2] = Release;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (v[k][c]) begin
          idx = -1;
          foreach (exp_q[i])
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k && exp_q[i].ch == c) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected %s[%0d] at cycle %0d: got 1 expected 0", kname(k), c, cyc);
          end else begin
            exp_q.delete(idx);
            if (k != 1) begin
              checks++;
              if (Level[c] !== (k == 0)) begin
                errors++;
                $display("FAIL level_with_%s[%0d] at cycle %0d: got %b expected %b",
                         kname(k), c, cyc, Level[c], (k == 0));
              end
            end
          end
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed %s[%0d] due at cycle %0d: got 0 expected 1",
                 kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r;
    Reset_n = 1'b0;
    KEY     = 3'b000;
    step(3);
    chk("reset_outputs_a", {Level, Press, Release, Repeat}, 12'h000);
    step(2);
    chk("reset_outputs_b", {Level, Press, Release, Repeat}, 12'h000);

    // Keys already pressed when reset lifts.
    Reset_n = 1'b1;
    b = cyc + 1;
    for (int c = 0; c < 3; c++) push_press(b + 6, c);
    at_edge(b + 5);
    chk("reset_exit_level_before", {9'd0, Level}, 12'h000);
    at_edge(b + 6);
    chk("reset_exit_level", {9'd0, Level}, 12'h007);
    KEY = 3'b111;
    b = cyc + 1;
    for (int c = 0; c < 3; c++) push(b + 6, 2, c);
    at_edge(b + 6);
    chk("release_all_level", {9'd0, Level}, 12'h000);
    step(5);

    // Clean press on key 1 with auto-repeat, released between repeats.
    KEY = 3'b101;
    b = cyc + 1;
    push_press(b + 6, 1);
    push(b + 17, 1, 1);
    push(b + 21, 1, 1);
    push(b + 25, 1, 1);
    at_edge(b + 5);
    chk("clean_level_before", {9'd0, Level}, 12'h000);
    at_edge(b + 6);
    chk("clean_level_after", {9'd0, Level}, 12'h002);
    at_edge(b + 25);
    KEY = 3'b111;
    r = cyc + 1;
    push(r + 6, 2, 1);
    at_edge(r + 5);
    chk("release_level_before", {9'd0, Level}, 12'h002);
    at_edge(r + 6);
    chk("release_level_after", {9'd0, Level}, 12'h000);
    step(5);

    // Bouncing key 0: three low, one high, five times.
    repeat (5) begin
      KEY[0] = 1'b0;
      step(3);
      KEY[0] = 1'b1;
      step(1);
    end
    chk("bounce_no_level", {9'd0, Level}, 12'h000);
    KEY[0] = 1'b0;
    b = cyc + 1;
    push_press(b + 6, 0);
    at_edge(b + 6);
    chk("bounce_settled_level", {9'd0, Level}, 12'h001);
    KEY = 3'b111;
    r = cyc + 1;
    push(r + 6, 2, 0);
    at_edge(r + 6);
    step(5);

    // Keys 0 and 2 two cycles apart; key 1 must stay quiet.
    KEY[0] = 1'b0;
    b = cyc + 1;
    push_press(b + 6, 0);
    step(2);
    KEY[2] = 1'b0;
    push_press(b + 8, 2);
    at_edge(b + 7);
    chk("indep_level_mid", {9'd0, Level}, 12'h001);
    at_edge(b + 9);
    chk("indep_level_both", {9'd0, Level}, 12'h005);
    KEY = 3'b111;
    r = cyc + 1;
    push(r + 6, 2, 0);
    push(r + 6, 2, 2);
    at_edge(r + 6);
    chk("indep_level_released", {9'd0, Level}, 12'h000);
    step(5);

    // Reset while key 1 is auto-repeating.
    KEY[1] = 1'b0;
    b = cyc + 1;
    push_press(b + 6, 1);
    push(b + 17, 1, 1);
    at_edge(b + 19);
    chk("pre_reset_level", {9'd0, Level}, 12'h002);
    Reset_n = 1'b0;
    #1;
    chk("reset_mid_hold", {Level, Press, Release, Repeat}, 12'h000);
    step(3);
    chk("reset_mid_hold_held", {Level, Press, Release, Repeat}, 12'h000);
    Reset_n = 1'b1;
    b = cyc + 1;
    push_press(b + 6, 1);
    at_edge(b + 6);
    chk("reset_fresh_level", {9'd0, Level}, 12'h002);
    KEY = 3'b111;
    r = cyc + 1;
    push(r + 6, 2, 1);
    at_edge(r + 6);
    step(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
